// File: rtl/hpu_pkg.sv
// Shared types for the HPU physical register file.
package hpu_pkg;

    localparam int PHY_SR_NUM = 64;
    localparam int PHY_SR_W   = $clog2(PHY_SR_NUM);
    localparam int DATA_W     = 32;

    typedef logic [PHY_SR_W-1:0] phy_sr_index_t;
    typedef logic [DATA_W-1:0]   data_t;

endpackage

// File: rtl/hpu_regfile_mp.sv
// One storage group of the physical register file: multi-write,
// multi-read, combinational read. The lowest-numbered write port wins
// when several enabled ports target the same entry.
module hpu_regfile_mp
    import hpu_pkg::*;
#(
    parameter int NUM_RD = 5,
    parameter int NUM_WR = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_WR-1:0]   wr_en_i,
    input  phy_sr_index_t       wr_index_i [NUM_WR],
    input  data_t               wr_data_i  [NUM_WR],
    input  phy_sr_index_t       rd_index_i [NUM_RD],
    output data_t               rd_data_o  [NUM_RD]
);

    data_t mem [PHY_SR_NUM];

    // Storage update; ports are applied high-to-low so port 0 lands last and wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PHY_SR_NUM; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int w = NUM_WR - 1; w >= 0; w--) begin
                if (wr_en_i[w]) begin
                    mem[wr_index_i[w]] <= wr_data_i[w];
                end
            end
        end
    end

    // Zero-latency read of the stored contents.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data_o[r] = mem[rd_index_i[r]];
        end
    end

endmodule

// File: rtl/hpu_prf_mp.sv
// Physical register file with replicated storage groups, a per-register
// ready scoreboard, same-cycle write forwarding and a sticky detector for
// duplicate write indices.
module hpu_prf_mp
    import hpu_pkg::*;
#(
    parameter int NUM_RD      = 10,
    parameter int NUM_WR      = 4,
    parameter int NUM_GRP     = 2,
    parameter int NUM_ALLOC   = 2,
    parameter int BYPASS_EN   = 1,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  phy_sr_index_t        rd_index_i    [NUM_RD],
    output data_t                rd_data_o     [NUM_RD],
    output logic [NUM_RD-1:0]    rd_ready_o,
    input  logic [NUM_WR-1:0]    wr_en_i,
    input  phy_sr_index_t        wr_index_i    [NUM_WR],
    input  data_t                wr_data_i     [NUM_WR],
    input  logic [NUM_ALLOC-1:0] alloc_en_i,
    input  phy_sr_index_t        alloc_index_i [NUM_ALLOC],
    input  logic                 flush_i,
    output logic                 wr_conflict_o
);

    localparam int RPG = NUM_RD / NUM_GRP;

    logic                  rst_q;
    logic                  blk;
    logic [NUM_WR-1:0]     we;
    logic [NUM_ALLOC-1:0]  ae;
    logic                  conf_hit;
    logic [PHY_SR_NUM-1:0] ready_q;
    logic [PHY_SR_NUM-1:0] ready_d;
    logic [NUM_RD-1:0]     byp_hit;
    data_t                 byp_data [NUM_RD];
    phy_sr_index_t         grp_idx  [NUM_GRP][RPG];
    data_t                 grp_rd   [NUM_GRP][RPG];

    // Remember reset for one edge after release so that edge drops writes/allocs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rst_q <= 1'b1;
        else       rst_q <= 1'b0;
    end

    assign blk = rst_i | rst_q;

    // Qualified write and allocation strobes: blocked around reset and for register 0.
    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            we[w] = wr_en_i[w] && !blk && !((ZERO_REG_EN != 0) && (wr_index_i[w] == '0));
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            ae[a] = alloc_en_i[a] && !blk && !((ZERO_REG_EN != 0) && (alloc_index_i[a] == '0));
        end
    end

    // Duplicate-index detection among qualified writes (empty when NUM_WR == 1).
    always_comb begin
        conf_hit = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (we[i] && we[j] && (wr_index_i[i] == wr_index_i[j])) begin
                    conf_hit = 1'b1;
                end
            end
        end
    end

    // Sticky conflict flag, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         wr_conflict_o <= 1'b0;
        else if (conf_hit) wr_conflict_o <= 1'b1;
    end

    // Ready scoreboard next state: writes set, allocations then clear; flush forces all ready.
    always_comb begin
        ready_d = ready_q;
        if (flush_i) begin
            ready_d = '1;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (we[w]) ready_d[wr_index_i[w]] = 1'b1;
            end
            for (int a = 0; a < NUM_ALLOC; a++) begin
                if (ae[a]) ready_d[alloc_index_i[a]] = 1'b0;
            end
        end
    end

    // Ready scoreboard register; everything is ready out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ready_q <= '1;
        else       ready_q <= ready_d;
    end

    // Fan read addresses out to the groups serving each block of read ports.
    always_comb begin
        for (int g = 0; g < NUM_GRP; g++) begin
            for (int k = 0; k < RPG; k++) begin
                grp_idx[g][k] = rd_index_i[g * RPG + k];
            end
        end
    end

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
        hpu_regfile_mp #(
            .NUM_RD (RPG),
            .NUM_WR (NUM_WR)
        ) u_rf (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .wr_en_i    (we),
            .wr_index_i (wr_index_i),
            .wr_data_i  (wr_data_i),
            .rd_index_i (grp_idx[g]),
            .rd_data_o  (grp_rd[g])
        );
    end

    // Forwarding lookup: lowest-numbered matching write port supplies the data.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            byp_hit[r]  = 1'b0;
            byp_data[r] = '0;
            for (int w = NUM_WR - 1; w >= 0; w--) begin
                if ((BYPASS_EN != 0) && we[w] && (wr_index_i[w] == rd_index_i[r])) begin
                    byp_hit[r]  = 1'b1;
                    byp_data[r] = wr_data_i[w];
                end
            end
        end
    end

    // Read output mux: register 0, then forwarded data, then group storage.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            if ((ZERO_REG_EN != 0) && (rd_index_i[r] == '0)) begin
                rd_data_o[r]  = '0;
                rd_ready_o[r] = 1'b1;
            end else begin
                rd_data_o[r]  = byp_hit[r] ? byp_data[r] : grp_rd[r / RPG][r % RPG];
                rd_ready_o[r] = ready_q[rd_index_i[r]] | byp_hit[r];
            end
        end
    end

endmodule

// File: tb/tb_hpu_prf_mp.sv
// Scoreboard bench for hpu_prf_mp: stimulus pushes expectations, a
// negedge monitor pops and compares them against the read ports.
module tb_hpu_prf_mp;
    import hpu_pkg::*;

    localparam int NRD = 10;
    localparam int NWR = 4;
    localparam int NAL = 2;

    logic          clk;
    logic          rst;
    phy_sr_index_t rd_index [NRD];
    data_t         rd_data  [NRD];
    logic [NRD-1:0] rd_ready;
    logic [NWR-1:0] wr_en;
    phy_sr_index_t wr_index [NWR];
    data_t         wr_data  [NWR];
    logic [NAL-1:0] alloc_en;
    phy_sr_index_t alloc_index [NAL];
    logic          flush;
    logic          wr_conflict;

    typedef struct {
        string name;
        int    port;
        data_t d;
        logic  r;
        logic  c;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests  = 0;
    int   failed = 0;

    hpu_prf_mp dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rd_index_i    (rd_index),
        .rd_data_o     (rd_data),
        .rd_ready_o    (rd_ready),
        .wr_en_i       (wr_en),
        .wr_index_i    (wr_index),
        .wr_data_i     (wr_data),
        .alloc_en_i    (alloc_en),
        .alloc_index_i (alloc_index),
        .flush_i       (flush),
        .wr_conflict_o (wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every expectation queued in a cycle is checked at its falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (rd_data[e.port] !== e.d || rd_ready[e.port] !== e.r || wr_conflict !== e.c) begin
                failed++;
                $display("FAIL %s port%0d: got data=%h rdy=%b conf=%b, want data=%h rdy=%b conf=%b",
                         e.name, e.port, rd_data[e.port], rd_ready[e.port], wr_conflict,
                         e.d, e.r, e.c);
            end
        end
    end

    task automatic expect_rd(input string name, input int port, input data_t d,
                             input logic r, input logic c);
        exp_t x;
        x.name = name; x.port = port; x.d = d; x.r = r; x.c = c;
        sb.push_back(x);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        wr_en    = '0;
        alloc_en = '0;
        flush    = 1'b0;
        for (int i = 0; i < NRD; i++) rd_index[i] = '0;
        for (int i = 0; i < NWR; i++) begin wr_index[i] = '0; wr_data[i] = '0; end
        for (int i = 0; i < NAL; i++) alloc_index[i] = '0;
    endtask

    task automatic wr(input int p, input int idx, input data_t d);
        wr_en[p]    = 1'b1;
        wr_index[p] = phy_sr_index_t'(idx);
        wr_data[p]  = d;
    endtask

    task automatic al(input int p, input int idx);
        alloc_en[p]    = 1'b1;
        alloc_index[p] = phy_sr_index_t'(idx);
    endtask

    task automatic rdp(input int p, input int idx);
        rd_index[p] = phy_sr_index_t'(idx);
    endtask

    initial begin
        rst = 1'b1;
        wr_en = '0; alloc_en = '0; flush = 1'b0;
        for (int i = 0; i < NRD; i++) rd_index[i] = '0;
        for (int i = 0; i < NWR; i++) begin wr_index[i] = '0; wr_data[i] = '0; end
        for (int i = 0; i < NAL; i++) alloc_index[i] = '0;

        // Reset state
        cyc(); cyc();
        rdp(0, 5); expect_rd("rst_rd", 0, 32'h0, 1'b1, 1'b0);
        expect_rd("rst_zero", 9, 32'h0, 1'b1, 1'b0);

        // Release: write/alloc in that cycle are discarded
        cyc(); rst = 1'b0;
        wr(0, 3, 32'hAA); al(0, 3); rdp(0, 3);
        expect_rd("rel_byp", 0, 32'h0, 1'b1, 1'b0);
        cyc(); rdp(0, 3);
        expect_rd("rel_discard", 0, 32'h0, 1'b1, 1'b0);

        // Register 0: writes, allocations and duplicates ignored
        cyc(); wr(0, 0, 32'hFFFF); wr(2, 0, 32'h1234); al(0, 0);
        rdp(0, 0); rdp(6, 0);
        expect_rd("zero_p0", 0, 32'h0, 1'b1, 1'b0);
        expect_rd("zero_p6", 6, 32'h0, 1'b1, 1'b0);
        cyc(); rdp(0, 0);
        expect_rd("zero_next", 0, 32'h0, 1'b1, 1'b0);

        // Write + same-cycle read on every port, then stored read
        cyc(); wr(0, 5, 32'hDEADBEEF);
        for (int p = 0; p < NRD; p++) begin
            rdp(p, 5); expect_rd("byp_all", p, 32'hDEADBEEF, 1'b1, 1'b0);
        end
        @(negedge clk);
        for (int p = 0; p < NRD; p++) begin
            tests++;
            if (rd_data[p] !== 32'hDEADBEEF || rd_ready[p] !== 1'b1) begin
                failed++;
                $display("FAIL byp_direct port%0d: got data=%h rdy=%b", p, rd_data[p], rd_ready[p]);
            end
        end
        cyc();
        for (int p = 0; p < NRD; p++) begin
            rdp(p, 5); expect_rd("store_all", p, 32'hDEADBEEF, 1'b1, 1'b0);
        end
        @(negedge clk);
        for (int p = 0; p < NRD; p++) begin
            tests++;
            if (rd_data[p] !== 32'hDEADBEEF || rd_ready[p] !== 1'b1) begin
                failed++;
                $display("FAIL store_direct port%0d: got data=%h rdy=%b", p, rd_data[p], rd_ready[p]);
            end
        end

        // Allocation clears ready; write sets it via bypass
        cyc(); al(0, 12); rdp(0, 12);
        expect_rd("alloc_same", 0, 32'h0, 1'b1, 1'b0);
        cyc(); rdp(0, 12);
        expect_rd("alloc_next", 0, 32'h0, 1'b0, 1'b0);
        cyc(); wr(2, 12, 32'h7); rdp(0, 12); rdp(7, 12);
        expect_rd("wr12_byp_p0", 0, 32'h7, 1'b1, 1'b0);
        expect_rd("wr12_byp_p7", 7, 32'h7, 1'b1, 1'b0);
        @(negedge clk);
        tests++;
        if (rd_data[7] !== 32'h7 || rd_ready[7] !== 1'b1) begin
            failed++;
            $display("FAIL wr12_direct: got data=%h rdy=%b", rd_data[7], rd_ready[7]);
        end
        cyc(); rdp(0, 12);
        expect_rd("wr12_store", 0, 32'h7, 1'b1, 1'b0);
        @(negedge clk);
        tests++;
        if (rd_data[0] !== 32'h7 || rd_ready[0] !== 1'b1) begin
            failed++;
            $display("FAIL wr12_store_direct: got data=%h rdy=%b", rd_data[0], rd_ready[0]);
        end

        // Allocation and write to the same index: data stored, ready cleared
        cyc(); al(1, 30); wr(1, 30, 32'h55); rdp(0, 30);
        expect_rd("alwr_byp", 0, 32'h55, 1'b1, 1'b0);
        cyc(); rdp(0, 30);
        expect_rd("alwr_next", 0, 32'h55, 1'b0, 1'b0);

        // Flush overrides a simultaneous allocation
        cyc(); al(0, 20); al(1, 21); rdp(0, 20);
        expect_rd("al20_same", 0, 32'h0, 1'b1, 1'b0);
        cyc(); flush = 1'b1; al(0, 22); rdp(0, 20); rdp(1, 21); rdp(2, 22);
        expect_rd("pre_fl_20", 0, 32'h0, 1'b0, 1'b0);
        expect_rd("pre_fl_21", 1, 32'h0, 1'b0, 1'b0);
        expect_rd("pre_fl_22", 2, 32'h0, 1'b1, 1'b0);
        cyc(); rdp(0, 20); rdp(1, 21); rdp(2, 22);
        expect_rd("flush_20", 0, 32'h0, 1'b1, 1'b0);
        expect_rd("flush_21", 1, 32'h0, 1'b1, 1'b0);
        expect_rd("flush_22", 2, 32'h0, 1'b1, 1'b0);

        // Duplicate write indices: port 1 wins, conflict sticks
        cyc(); wr(1, 9, 32'h11); wr(3, 9, 32'h33); rdp(0, 9); rdp(9, 9);
        expect_rd("dup_byp_p0", 0, 32'h11, 1'b1, 1'b0);
        expect_rd("dup_byp_p9", 9, 32'h11, 1'b1, 1'b0);
        cyc(); rdp(0, 9);
        expect_rd("dup_store", 0, 32'h11, 1'b1, 1'b1);
        @(negedge clk);
        tests++;
        if (wr_conflict !== 1'b1 || rd_data[0] !== 32'h11) begin
            failed++;
            $display("FAIL dup_direct: got data=%h conf=%b", rd_data[0], wr_conflict);
        end
        cyc(); rdp(0, 5);
        expect_rd("dup_sticky", 0, 32'hDEADBEEF, 1'b1, 1'b1);

        // Mid-stream reset: everything clears immediately
        cyc(); rst = 1'b1; wr(0, 5, 32'h99); rdp(0, 5); rdp(1, 9); rdp(2, 12);
        expect_rd("mrst_5", 0, 32'h0, 1'b1, 1'b0);
        expect_rd("mrst_9", 1, 32'h0, 1'b1, 1'b0);
        expect_rd("mrst_12", 2, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        tests++;
        if (wr_conflict !== 1'b0 || rd_data[0] !== 32'h0 || rd_ready[0] !== 1'b1) begin
            failed++;
            $display("FAIL mrst_direct: got data=%h rdy=%b conf=%b", rd_data[0], rd_ready[0], wr_conflict);
        end
        cyc(); rdp(0, 30);
        expect_rd("mrst_30", 0, 32'h0, 1'b1, 1'b0);
        cyc(); rst = 1'b0;
        cyc(); rdp(0, 5); rdp(1, 9);
        expect_rd("post_5", 0, 32'h0, 1'b1, 1'b0);
        expect_rd("post_9", 1, 32'h0, 1'b1, 1'b0);

        cyc(); cyc();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            failed++;
            $display("FAIL %s port%0d: never checked, want data=%h", e.name, e.port, e.d);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
